sync_clk_slow_to_fast_clap: RTL and testbench

Slow-to-fast clock-domain-crossing pulse synchronizer. A level/strobe produced by a register in the slow domain (`signal_in`) passes through a flip-flop synchronizer chain clocked by `clk_fast`. An edge detector then produces a clean, single-`clk_fast`-cycle pulse (or a synchronized level) on `signal_out`. It sits at the boundary of every slow-to-fast control-strobe crossing.

---
 rtl/cdc_pkg.sv | 29 ++
 rtl/sync_ff_chain.sv | 31 +++
 rtl/sync_clk_slow_to_fast_clap.sv | 55 +++++
 tb/tb_sync_clk_slow_to_fast_clap.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// Shared constants and output-selection helper for the clock-domain-crossing synchronizers.
`timescale 1ns/1ps
package cdc_pkg;

   localparam int unsigned MODE_RISE       = 0;
   localparam int unsigned MODE_FALL       = 1;
   localparam int unsigned MODE_BOTH       = 2;
   localparam int unsigned MODE_LEVEL      = 3;
   localparam int unsigned MODE_W          = 2;

   localparam int unsigned SYNC_STAGES_MIN = 2;
   localparam int unsigned SYNC_STAGES_MAX = 4;

   // Select the next output from the synchronized level and its one-cycle history.
   function automatic logic edge_sel(input logic [MODE_W-1:0] mode,
                                     input logic              s,
                                     input logic              prev);
      logic r;
      r = 1'b0;
      case (mode)
         MODE_W'(MODE_RISE):  r = s & ~prev;
         MODE_W'(MODE_FALL):  r = ~s & prev;
         MODE_W'(MODE_BOTH):  r = s ^ prev;
         default:             r = s;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// Multi-flop synchronizer chain; the first flop may go metastable, the rest resolve it.
`timescale 1ns/1ps
module sync_ff_chain
   import cdc_pkg::*;
#(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   if (STAGES < SYNC_STAGES_MIN || STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
      $error("sync_ff_chain: STAGES must be between 2 and 4");
   end

   // Keep these flops together and out of retiming.
   (* ASYNC_REG = "TRUE", DONT_TOUCH = "TRUE" *) logic [STAGES-1:0] r_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], d};
      end
   end

   assign q = r_sync[STAGES-1];

endmodule

// File: rtl/sync_clk_slow_to_fast_clap.sv
// Slow-to-fast pulse synchronizer: flop chain, one-cycle history and a registered edge/level select.
`timescale 1ns/1ps
module sync_clk_slow_to_fast_clap
   import cdc_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned OUT_MODE    = MODE_RISE
) (
   input  logic clk_fast,
   input  logic rst_n,
   input  logic clk_slow,
   input  logic signal_in,
   output logic signal_out
);

   if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
      $error("sync_clk_slow_to_fast_clap: SYNC_STAGES must be between 2 and 4");
   end
   if (OUT_MODE > MODE_LEVEL) begin : g_bad_mode
      $error("sync_clk_slow_to_fast_clap: OUT_MODE must be between 0 and 3");
   end

   logic w_s;
   logic w_next;
   logic r_prev;
   logic r_out;
   logic w_unused_clk_slow;

   // Source clock only exists on the port list for integration symmetry.
   assign w_unused_clk_slow = clk_slow;

   sync_ff_chain #(
      .STAGES (SYNC_STAGES)
   ) u_chain (
      .clk   (clk_fast),
      .rst_n (rst_n),
      .d     (signal_in),
      .q     (w_s)
   );

   assign w_next = edge_sel(MODE_W'(OUT_MODE), w_s, r_prev);

   always_ff @(posedge clk_fast or negedge rst_n) begin
      if (!rst_n) begin
         r_prev <= 1'b0;
         r_out  <= 1'b0;
      end else begin
         r_prev <= w_s;
         r_out  <= w_next;
      end
   end

   assign signal_out = r_out;

endmodule

// File: tb/tb_sync_clk_slow_to_fast_clap.sv
// Bench for the slow-to-fast pulse synchronizer across four mode/depth configurations.
`timescale 1ns/1ps
module tb_sync_clk_slow_to_fast_clap;

   logic clk_fast = 1'b0;
   logic clk_slow = 1'b1;
   logic rst_n    = 1'b0;
   logic signal_in = 1'b0;
   logic o_m0, o_m1, o_m2, o_m3;

   int n_checks = 0;
   int n_errors = 0;

   always #5  clk_fast = ~clk_fast;
   always #10 clk_slow = ~clk_slow;

   // mode 0 / 2 stages, mode 1 / 4 stages, mode 2 / 2 stages, mode 3 / 3 stages
   sync_clk_slow_to_fast_clap #(.SYNC_STAGES(2), .OUT_MODE(0)) u_dut_m0 (
      .clk_fast(clk_fast), .rst_n(rst_n), .clk_slow(clk_slow), .signal_in(signal_in), .signal_out(o_m0));
   sync_clk_slow_to_fast_clap #(.SYNC_STAGES(4), .OUT_MODE(1)) u_dut_m1 (
      .clk_fast(clk_fast), .rst_n(rst_n), .clk_slow(clk_slow), .signal_in(signal_in), .signal_out(o_m1));
   sync_clk_slow_to_fast_clap #(.SYNC_STAGES(2), .OUT_MODE(2)) u_dut_m2 (
      .clk_fast(clk_fast), .rst_n(rst_n), .clk_slow(clk_slow), .signal_in(signal_in), .signal_out(o_m2));
   sync_clk_slow_to_fast_clap #(.SYNC_STAGES(3), .OUT_MODE(3)) u_dut_m3 (
      .clk_fast(clk_fast), .rst_n(rst_n), .clk_slow(clk_slow), .signal_in(signal_in), .signal_out(o_m3));

   task automatic check_eq(input string tag, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %b expected %b", tag, $time, act, exp);
      end
   endtask

   // Reference: history of input values captured at each fast edge since reset, newest first.
   logic hist[$];

   always @(posedge clk_fast or negedge rst_n) begin
      if (!rst_n) begin
         hist.delete();
      end else begin
         hist.push_front(signal_in);
         if (hist.size() > 8) void'(hist.pop_back());
      end
   end

   function automatic logic hist_at(input int unsigned age);
      return (age < hist.size()) ? hist[age] : 1'b0;
   endfunction

   // Output after an edge reflects the input captured STAGES and STAGES+1 edges earlier.
   function automatic logic model_out(input int unsigned mode, input int unsigned stages);
      logic cur, old;
      cur = hist_at(stages);
      old = hist_at(stages + 1);
      case (mode)
         0:       return cur && !old;
         1:       return !cur && old;
         2:       return cur != old;
         default: return cur;
      endcase
   endfunction

   always @(negedge clk_fast) begin
      check_eq("sb_m0", o_m0, model_out(0, 2));
      check_eq("sb_m1", o_m1, model_out(1, 4));
      check_eq("sb_m2", o_m2, model_out(2, 2));
      check_eq("sb_m3", o_m3, model_out(3, 3));
   end

   // Pulse counters for the edge-preservation stress phase.
   logic count_en = 1'b0;
   int   cnt_m0 = 0, cnt_m1 = 0, cnt_m2 = 0;

   always @(negedge clk_fast) begin
      if (count_en) begin
         cnt_m0 += int'(o_m0);
         cnt_m1 += int'(o_m1);
         cnt_m2 += int'(o_m2);
      end
   end

   task automatic wait_to(input longint t);
      if ($time < t) #(t - $time);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish, at %0t", $time);
      $fatal(1);
   end

   initial begin
      int rises;
      int falls;
      int hold;

      // Reset window: outputs stay low.
      wait_to(12);
      check_eq("rst_m0", o_m0, 1'b0);
      check_eq("rst_m3", o_m3, 1'b0);
      wait_to(20);
      rst_n = 1'b1;
      wait_to(50);
      check_eq("post_rst_m0", o_m0, 1'b0);
      check_eq("post_rst_m2", o_m2, 1'b0);

      // Rise at 60 ns, captured at 65 ns.
      wait_to(60);
      signal_in = 1'b1;
      wait_to(80);
      check_eq("rise_early_m0", o_m0, 1'b0);
      wait_to(90);
      check_eq("rise_pulse_m0", o_m0, 1'b1);
      check_eq("rise_pulse_m2", o_m2, 1'b1);
      check_eq("rise_none_m1", o_m1, 1'b0);
      wait_to(100);
      check_eq("rise_end_m0", o_m0, 1'b0);
      check_eq("rise_end_m2", o_m2, 1'b0);
      check_eq("level_on_m3", o_m3, 1'b1);
      signal_in = 1'b0;
      wait_to(120);
      check_eq("level_mid_m3", o_m3, 1'b1);
      wait_to(130);
      check_eq("fall_none_m0", o_m0, 1'b0);
      check_eq("fall_pulse_m2", o_m2, 1'b1);
      check_eq("level_last_m3", o_m3, 1'b1);
      wait_to(140);
      check_eq("fall_end_m2", o_m2, 1'b0);
      check_eq("level_off_m3", o_m3, 1'b0);
      check_eq("fall_early_m1", o_m1, 1'b0);
      wait_to(150);
      check_eq("fall_pulse_m1", o_m1, 1'b1);
      wait_to(160);
      check_eq("fall_end_m1", o_m1, 1'b0);

      // Reset while a pulse is being driven.
      wait_to(200);
      signal_in = 1'b1;
      wait_to(230);
      check_eq("flight_m0", o_m0, 1'b1);
      check_eq("flight_m2", o_m2, 1'b1);
      wait_to(231);
      rst_n = 1'b0;
      wait_to(232);
      check_eq("rst_drop_m0", o_m0, 1'b0);
      check_eq("rst_drop_m2", o_m2, 1'b0);
      wait_to(250);
      check_eq("rst_hold_m3", o_m3, 1'b0);
      wait_to(260);
      rst_n = 1'b1;
      wait_to(280);
      check_eq("rel_early_m0", o_m0, 1'b0);
      wait_to(290);
      check_eq("rel_pulse_m0", o_m0, 1'b1);
      wait_to(300);
      check_eq("rel_end_m0", o_m0, 1'b0);
      wait_to(320);
      check_eq("rel_single_m0", o_m0, 1'b0);
      check_eq("rel_level_m3", o_m3, 1'b1);

      // Stress: random 2..8-cycle levels, 1000 input edges.
      wait_to(400);
      signal_in = 1'b0;
      repeat (10) @(negedge clk_fast);
      rises = 0;
      falls = 0;
      count_en = 1'b1;
      for (int e = 0; e < 1000; e++) begin
         signal_in = ~signal_in;
         if (signal_in) rises++;
         else           falls++;
         hold = int'($urandom_range(8, 2));
         repeat (hold) @(negedge clk_fast);
      end
      signal_in = 1'b0;
      repeat (12) @(negedge clk_fast);
      count_en = 1'b0;
      n_checks++;
      if (cnt_m0 != rises) begin
         n_errors++;
         $display("FAIL stress_m0 pulses: got %0d expected %0d", cnt_m0, rises);
      end
      n_checks++;
      if (cnt_m1 != falls) begin
         n_errors++;
         $display("FAIL stress_m1 pulses: got %0d expected %0d", cnt_m1, falls);
      end
      n_checks++;
      if (cnt_m2 != rises + falls) begin
         n_errors++;
         $display("FAIL stress_m2 pulses: got %0d expected %0d", cnt_m2, rises + falls);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
